// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative multiplier producing the full 2*WIDTH-bit product of two WIDTH-bit
// operands, consuming STEP multiplier bits per clock (N = WIDTH/STEP cycles).
// Each transaction selects signed (two's-complement) or unsigned operation.
// Signed operands are converted to magnitudes on capture, multiplied as
// unsigned numbers, and the sign is restored on the final product. This keeps
// the iteration datapath purely unsigned.
//
// Parameters
//   WIDTH  operand width in bits (>= 2)
//   STEP   multiplier bits retired per iteration; must divide WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode are valid
//   in_ready   block can accept a new operation (IDLE only)
//   in_signed  1 = two's-complement operands/result, 0 = unsigned
//   in_a       multiplicand
//   in_b       multiplier
//   out_valid  out_p holds a finished product
//   out_ready  consumer accepts out_p
//   out_p      2*WIDTH-bit product (registered, stable while out_valid)
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int N     = WIDTH / STEP;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state;
  logic [PW-1:0]      mcand_q;   // multiplicand, pre-shifted to current bit position
  logic [WIDTH-1:0]   mplier_q;  // remaining multiplier bits, LSB-aligned
  logic [PW-1:0]      acc_q;     // running unsigned product of the magnitudes
  logic               neg_q;     // final product must be negated
  logic [CNT_W-1:0]   cnt_q;     // iteration index within BUSY

  logic [STEP-1:0]    digit;
  logic [PW-1:0]      partial;
  logic [PW-1:0]      acc_sum;

  // Magnitude of an operand; in signed mode the most negative value maps to
  // 2^(WIDTH-1), which is still representable as a WIDTH-bit unsigned number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             use_sign);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    if (use_sign && sv < 0) begin
      return $unsigned(-sv);
    end
    return v;
  endfunction

  // Restore the sign of the product; negation is exact in 2*WIDTH bits.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                               input logic          neg);
    logic signed [PW-1:0] smag;
    smag = $signed(mag);
    return neg ? $unsigned(-smag) : mag;
  endfunction

  // One radix-2^STEP partial product per cycle. The multiplicand register is
  // already shifted to the digit's weight, so no variable shifter is needed.
  always_comb begin
    digit   = mplier_q[STEP-1:0];
    partial = mcand_q * PW'(digit);
    acc_sum = acc_q + partial;
  end

  // in_ready is a pure function of state (gated low while reset is held), so
  // there is no combinational path from in_valid or out_ready.
  assign in_ready = rst_n & (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_p     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q  <= PW'(magnitude(in_a, in_signed));
            mplier_q <= magnitude(in_b, in_signed);
            neg_q    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            state    <= S_BUSY;
          end
        end

        // Iteration stage: accumulate, retire STEP multiplier bits.
        S_BUSY: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            // The last accumulation goes straight into the output register so
            // out_valid rises exactly N cycles after acceptance.
            out_p     <= apply_sign(acc_sum, neg_q);
            out_valid <= 1'b1;
            cnt_q     <= '0;
            state     <= S_DONE;
          end
        end

        // Result stage: hold out_p until the consumer takes it.
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
